fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 64, legal 2..255: maximum beats per grant before forced release.
REQ-002 i_clk  input  1  single clock; all logic rising-edge.
REQ-003 i_reset_n  input  1  asynchronous, active-low reset.
REQ-004 i_req  input  4  per-requester beat-valid, bit k = requester k.
REQ-005 i_last  input  4  per-requester end-of-burst marker, qualified by i_req[k].
REQ-006 i_data0..i_data3  input  66 each  64b/66b block from requester k.
REQ-007 o_ack  output  4  beat k accepted this cycle.
REQ-008 i_full  input  1  downstream FIFO full flag, write-clock domain.
REQ-009 o_push  output  1  FIFO push strobe.
REQ-010 o_wdata  output  66  FIFO write data.
REQ-011 o_grant  output  4  one-hot current owner, all-zero when idle.
REQ-012 o_busy  output  1  high in BURST state.
REQ-013 o_err  output  1  sticky burst-overrun flag.
REQ-014 o_err_port  output  2  requester index of most recent overrun.

Function
REQ-015 FSM states IDLE and BURST; registers: state, grant index g (2b), rr_ptr (2b), beat_cnt (8b), o_err, o_err_port.
REQ-016 IDLE: if i_req nonzero, select first k with i_req[k] searching rr_ptr, rr_ptr+1, ... mod 4; next cycle state=BURST, g=k, beat_cnt=0; no beat accepted in IDLE.
REQ-017 IDLE with i_req=0: remain IDLE, rr_ptr unchanged.
REQ-018 BURST: beat accepted (accept=1) iff i_req[g] && !i_full; combinational same cycle.
REQ-019 o_push = accept; o_ack = accept ? one-hot(g) : 0; o_wdata = i_data[g] whenever BURST, 0 in IDLE.
REQ-020 o_grant = one-hot(g) in BURST, 0 in IDLE; o_busy = (state==BURST).
REQ-021 Non-granted requesters never acked; their i_req is ignored until re-arbitration.
REQ-022 BURST with i_req[g]=0 or i_full=1: stall, no push, beat_cnt held, no timeout on stall.
REQ-023 Accepted beat with i_last[g]=1: next state IDLE, rr_ptr=(g+1) mod 4, beat_cnt=0.
REQ-024 Accepted beat with i_last[g]=0: beat_cnt+1; if new beat_cnt==MAX_BURST, forced release: state IDLE, rr_ptr=(g+1) mod 4, o_err=1, o_err_port=g.
REQ-025 Last and MAX_BURST on same beat: treated as normal end (REQ-023), o_err unchanged.
REQ-026 Grant-to-first-push latency 1 cycle; exactly one IDLE bubble cycle between consecutive bursts.
REQ-027 o_err sticky until reset; o_err_port overwritten on each overrun.
REQ-028 Throughput: one 66-bit beat per cycle while granted requester valid and !i_full.
REQ-029 i_full sampled combinationally; block never pushes in a cycle with i_full=1.

Reset
REQ-030 i_reset_n low asynchronously forces state=IDLE, g=0, rr_ptr=0, beat_cnt=0, o_err=0, o_err_port=0.
REQ-031 During reset: o_push=0, o_ack=0, o_grant=0, o_busy=0, o_wdata=0.
REQ-032 Reset mid-burst abandons burst, no partial-state retention; release synchronous to i_clk, first grant possible on second rising edge after deassertion.

Verification
REQ-033 Single requester: i_req=0001, 3 beats D0..D2, last on D2, i_full=0 -> o_grant=0001 after 1 cycle, o_push 3 consecutive cycles with D0,D1,D2, IDLE next, rr_ptr=1.
REQ-034 Fairness: i_req=1111 continuously, each burst 2 beats -> grant order 0,1,2,3,0, one bubble between bursts, o_ack only to owner.
REQ-035 Backpressure: granted port 2, i_full=1 for 5 cycles mid-burst -> o_push=0, o_ack=0 those cycles, beat_cnt held, data order preserved after i_full=0.
REQ-036 Overrun: MAX_BURST=4, port 3 sends 6 beats no last -> 4 pushes, release, o_err=1, o_err_port=3, next grant searches from port 0.
REQ-037 Last at limit: MAX_BURST=4, last on beat 4 -> normal release, o_err stays 0.
REQ-038 Reset mid-burst: i_reset_n low during beat 2 -> outputs 0 immediately, o_err=0, after release requester 0 (rr_ptr=0) wins when i_req=1111.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Four-way round-robin burst arbiter that merges 64b/66b block streams from
// four requesters into a single downstream FIFO write port. A requester owns
// the FIFO for a whole burst, which ends on its i_last beat or is forcibly
// released after MAX_BURST beats. A forced release is recorded as an overrun.
//
// Ports
//   i_clk        single clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_req[3:0]   per-requester beat valid
//   i_last[3:0]  per-requester end-of-burst marker (qualified by i_req)
//   i_data0..3   66-bit block from each requester
//   i_full       downstream FIFO full flag
//   o_ack[3:0]   beat from requester k accepted this cycle
//   o_push       FIFO push strobe
//   o_wdata      FIFO write data
//   o_grant[3:0] one-hot current owner, zero when idle
//   o_busy       burst in progress
//   o_err        sticky burst-overrun flag
//   o_err_port   requester index of the most recent overrun
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int MAX_BURST = 64
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [3:0]  i_req,
    input  logic [3:0]  i_last,
    input  logic [65:0] i_data0,
    input  logic [65:0] i_data1,
    input  logic [65:0] i_data2,
    input  logic [65:0] i_data3,
    input  logic        i_full,
    output logic [3:0]  o_ack,
    output logic        o_push,
    output logic [65:0] o_wdata,
    output logic [3:0]  o_grant,
    output logic        o_busy,
    output logic        o_err,
    output logic [1:0]  o_err_port
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    state_t      state, state_nxt;
    logic [1:0]  g, g_nxt;
    logic [1:0]  rr_ptr, rr_nxt;
    logic [7:0]  beat_cnt, beat_nxt;
    logic [7:0]  beat_inc;
    logic        err_nxt;
    logic [1:0]  err_port_nxt;
    logic        armed;

    logic        pick_valid;
    logic [1:0]  pick_idx;
    logic [1:0]  cand;
    logic [3:0]  g_onehot;
    logic [65:0] data_sel;
    logic        accept;

    // Round-robin search starting at rr_ptr. The loop runs from the farthest
    // offset down to offset 0 so the closest requester overwrites the others.
    // NOTE: every variable driven here gets a default before any condition,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = rr_ptr;
        cand       = rr_ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = rr_ptr + 2'(i);
            if (i_req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        case (g)
            2'd0:    data_sel = i_data0;
            2'd1:    data_sel = i_data1;
            2'd2:    data_sel = i_data2;
            default: data_sel = i_data3;
        endcase
    end

    assign g_onehot = 4'b0001 << g;
    assign accept   = (state == BURST) && i_req[g] && !i_full;
    assign beat_inc = beat_cnt + 8'd1;

    assign o_busy   = (state == BURST);
    assign o_push   = accept;
    assign o_ack    = accept ? g_onehot : 4'b0000;
    assign o_grant  = o_busy ? g_onehot : 4'b0000;
    assign o_wdata  = o_busy ? data_sel : '0;

    always_comb begin
        state_nxt    = state;
        g_nxt        = g;
        rr_nxt       = rr_ptr;
        beat_nxt     = beat_cnt;
        err_nxt      = o_err;
        err_port_nxt = o_err_port;
        case (state)
            IDLE: begin
                // No beat is taken here; the winner starts pushing next cycle.
                if (armed && pick_valid) begin
                    state_nxt = BURST;
                    g_nxt     = pick_idx;
                    beat_nxt  = 8'd0;
                end
            end
            BURST: begin
                // Stalls (no request or FIFO full) leave everything untouched.
                if (accept) begin
                    if (i_last[g]) begin
                        state_nxt = IDLE;
                        rr_nxt    = g + 2'd1;
                        beat_nxt  = 8'd0;
                    end else if (beat_inc == BURST_LIMIT) begin
                        state_nxt    = IDLE;
                        rr_nxt       = g + 2'd1;
                        beat_nxt     = 8'd0;
                        err_nxt      = 1'b1;
                        err_port_nxt = g;
                    end else begin
                        beat_nxt = beat_inc;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // armed holds off arbitration for the first edge after reset release, so
    // the earliest grant lands on the second rising edge.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            g          <= 2'd0;
            rr_ptr     <= 2'd0;
            beat_cnt   <= 8'd0;
            o_err      <= 1'b0;
            o_err_port <= 2'd0;
            armed      <= 1'b0;
        end else begin
            state      <= state_nxt;
            g          <= g_nxt;
            rr_ptr     <= rr_nxt;
            beat_cnt   <= beat_nxt;
            o_err      <= err_nxt;
            o_err_port <= err_port_nxt;
            armed      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Per-requester source queues feed the arbiter; the expected FIFO write
// sequence (data and owning port) is queued when a scenario is loaded and
// popped whenever the DUT pushes. Cycle-level checks cover grant latency,
// bubbles, backpressure, overrun and reset behaviour. MAX_BURST is set to 4.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic [1:0]  port;
        logic [65:0] data;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [3:0]  i_req;
    logic [3:0]  i_last;
    logic [65:0] data_drv [4];
    logic        i_full;
    logic [3:0]  o_ack;
    logic        o_push;
    logic [65:0] o_wdata;
    logic [3:0]  o_grant;
    logic        o_busy;
    logic        o_err;
    logic [1:0]  o_err_port;

    logic [66:0] src_q [4][$];
    exp_t        exp_q [$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n;

    always #5 i_clk = ~i_clk;

    fifo_wr_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_req      (i_req),
        .i_last     (i_last),
        .i_data0    (data_drv[0]),
        .i_data1    (data_drv[1]),
        .i_data2    (data_drv[2]),
        .i_data3    (data_drv[3]),
        .i_full     (i_full),
        .o_ack      (o_ack),
        .o_push     (o_push),
        .o_wdata    (o_wdata),
        .o_grant    (o_grant),
        .o_busy     (o_busy),
        .o_err      (o_err),
        .o_err_port (o_err_port)
    );

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [65:0] beat_word(input int t, input int p, input int i);
        return {2'b10, 8'(t), 8'(p), 8'(i), 40'h5A5A_C3C3_00};
    endfunction

    function automatic bit sources_empty();
        for (int k = 0; k < 4; k++)
            if (src_q[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Queue n beats for port p (indices first..first+n-1); last only on the final one.
    task automatic load_port(input int t, input int p, input int first, input int cnt, input bit last_final);
        for (int i = 0; i < cnt; i++)
            src_q[p].push_back({(last_final && i == cnt - 1), beat_word(t, p, first + i)});
    endtask

    task automatic expect_beats(input int t, input int p, input int first, input int cnt);
        exp_t e;
        for (int i = 0; i < cnt; i++) begin
            e.port = 2'(p);
            e.data = beat_word(t, p, first + i);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            if (src_q[k].size() != 0) begin
                i_req[k]    = 1'b1;
                i_last[k]   = src_q[k][0][66];
                data_drv[k] = src_q[k][0][65:0];
            end else begin
                i_req[k]    = 1'b0;
                i_last[k]   = 1'b0;
                data_drv[k] = '0;
            end
        end
    endtask

    // One clock: capture acks before the edge, retire acked beats after it.
    task automatic tick();
        logic [3:0] ack_s;
        #1;
        ack_s = o_ack;
        @(posedge i_clk);
        #1;
        for (int k = 0; k < 4; k++)
            if (ack_s[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
        drive();
        #1;
    endtask

    task automatic run_until_done(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget && !(sources_empty() && !o_busy)) begin
            tick();
            cycles++;
        end
        check("drain_within_budget", (sources_empty() && !o_busy), 1'b1);
    endtask

    // Scoreboard: every push must match the head of the expected queue.
    always @(negedge i_clk) begin
        if (i_full) check("no_push_when_full", o_push, 1'b0);
        if (o_push) begin
            if (exp_q.size() == 0) begin
                check("push_with_queue_depth", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                check("push_wdata", o_wdata, mon_e.data);
                check("push_ack_owner", o_ack, 4'b0001 << mon_e.port);
            end
        end else begin
            check("ack_without_push", o_ack, 4'b0000);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset_n = 1'b0;
        i_full    = 1'b0;
        drive();
        repeat (2) @(posedge i_clk);
        #2;
        check("rst_push",     o_push,     1'b0);
        check("rst_ack",      o_ack,      4'b0000);
        check("rst_grant",    o_grant,    4'b0000);
        check("rst_busy",     o_busy,     1'b0);
        check("rst_wdata",    o_wdata,    66'd0);
        check("rst_err",      o_err,      1'b0);
        check("rst_err_port", o_err_port, 2'd0);
        i_reset_n = 1'b1;
        tick();
        tick();

        // Fairness: all four request, 2-beat bursts, port 0 has two bursts.
        load_port(1, 0, 0, 2, 1'b1);
        load_port(1, 0, 2, 2, 1'b1);
        load_port(1, 1, 0, 2, 1'b1);
        load_port(1, 2, 0, 2, 1'b1);
        load_port(1, 3, 0, 2, 1'b1);
        expect_beats(1, 0, 0, 2);
        expect_beats(1, 1, 0, 2);
        expect_beats(1, 2, 0, 2);
        expect_beats(1, 3, 0, 2);
        expect_beats(1, 0, 2, 2);
        drive();
        #1;
        run_until_done(100, n);
        check("fair_cycles_with_bubbles", n, 15);
        check("fair_sb_empty", exp_q.size(), 0);

        // Single requester, 3 beats: grant after one cycle, 3 back-to-back pushes.
        load_port(2, 0, 0, 3, 1'b1);
        expect_beats(2, 0, 0, 3);
        drive();
        #1;
        check("single_idle_grant", o_grant, 4'b0000);
        tick();
        check("single_grant", o_grant, 4'b0001);
        check("single_push0", o_push, 1'b1);
        tick();
        check("single_push1", o_push, 1'b1);
        tick();
        check("single_push2", o_push, 1'b1);
        tick();
        check("single_busy_after", o_busy, 1'b0);
        check("single_push_after", o_push, 1'b0);
        check("single_sb_empty", exp_q.size(), 0);

        // Last on the beat that reaches MAX_BURST: normal end, no error.
        load_port(3, 1, 0, MAX_BURST, 1'b1);
        expect_beats(3, 1, 0, MAX_BURST);
        drive();
        #1;
        run_until_done(100, n);
        check("limit_last_cycles", n, MAX_BURST + 1);
        check("limit_last_no_err", o_err, 1'b0);

        // Backpressure on port 2: 5 full cycles mid-burst.
        load_port(4, 2, 0, 3, 1'b1);
        expect_beats(4, 2, 0, 3);
        drive();
        #1;
        tick();
        check("bp_grant", o_grant, 4'b0100);
        tick();
        i_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_stall_push", o_push, 1'b0);
            check("bp_stall_ack",  o_ack,  4'b0000);
            check("bp_stall_busy", o_busy, 1'b1);
            tick();
        end
        i_full = 1'b0;
        run_until_done(100, n);
        check("bp_no_err", o_err, 1'b0);
        check("bp_sb_empty", exp_q.size(), 0);

        // Overrun on port 3; port 0 waits and wins the re-arbitration.
        load_port(5, 3, 0, 6, 1'b1);
        load_port(5, 0, 0, 1, 1'b1);
        expect_beats(5, 3, 0, 4);
        expect_beats(5, 0, 0, 1);
        expect_beats(5, 3, 4, 2);
        drive();
        #1;
        run_until_done(100, n);
        check("ovr_cycles", n, 10);
        check("ovr_err", o_err, 1'b1);
        check("ovr_err_port", o_err_port, 2'd3);
        check("ovr_sb_empty", exp_q.size(), 0);

        // Reset during the second beat of a port 1 burst.
        load_port(6, 1, 0, 4, 1'b1);
        expect_beats(6, 1, 0, 1);
        drive();
        #1;
        tick();
        tick();
        i_reset_n = 1'b0;
        #1;
        check("mid_rst_push",     o_push,     1'b0);
        check("mid_rst_ack",      o_ack,      4'b0000);
        check("mid_rst_grant",    o_grant,    4'b0000);
        check("mid_rst_busy",     o_busy,     1'b0);
        check("mid_rst_wdata",    o_wdata,    66'd0);
        check("mid_rst_err",      o_err,      1'b0);
        check("mid_rst_err_port", o_err_port, 2'd0);
        check("mid_rst_sb_empty", exp_q.size(), 0);
        for (int k = 0; k < 4; k++) src_q[k].delete();
        drive();
        @(posedge i_clk);
        #3;
        i_reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            load_port(7, k, 0, 1, 1'b1);
            expect_beats(7, k, 0, 1);
        end
        drive();
        #1;
        check("post_rst_grant_pre", o_grant, 4'b0000);
        tick();
        check("post_rst_grant_edge1", o_grant, 4'b0000);
        tick();
        check("post_rst_grant_edge2", o_grant, 4'b0001);
        run_until_done(100, n);
        check("post_rst_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
